muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_pkg.sv | 37 +++
 rtl/muldiv_unit_signfix.sv | 35 +++
 rtl/muldiv_unit.sv | 145 ++++++++++++++
 tb/tb_muldiv_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared defines for the iterative multiply/divide unit: op codes, FSM
// states, default iteration count and the ALU selection codes.
package muldiv_unit_pkg;

  localparam int ITER_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_sel_e;

endpackage

// File: rtl/muldiv_unit_signfix.sv
// Operand magnitude extraction and final sign correction, shared by the
// accept path (magnitudes) and the FIX path (negation of the raw result).
module muldiv_signfix
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        func3,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  input  logic [2*XLEN-1:0] raw_main,
  input  logic [XLEN-1:0]   raw_rem,
  output logic [XLEN-1:0]   mag_a,
  output logic [XLEN-1:0]   mag_b,
  output logic [2*XLEN-1:0] fixed_main,
  output logic [XLEN-1:0]   fixed_rem
);

  logic signed_a, signed_b, neg_a, neg_b;

  always_comb begin
    signed_a = (func3 == OP_MUL) || (func3 == OP_MULH) || (func3 == OP_MULHSU) ||
               (func3 == OP_DIV) || (func3 == OP_REM);
    signed_b = (func3 == OP_MUL) || (func3 == OP_MULH) ||
               (func3 == OP_DIV) || (func3 == OP_REM);
    neg_a = signed_a && op_a[XLEN-1];
    neg_b = signed_b && op_b[XLEN-1];
    mag_a = neg_a ? ({XLEN{1'b0}} - op_a) : op_a;
    mag_b = neg_b ? ({XLEN{1'b0}} - op_b) : op_b;
    // Product and quotient take the XOR of signs; remainder follows the dividend.
    fixed_main = (neg_a ^ neg_b) ? ({(2*XLEN){1'b0}} - raw_main) : raw_main;
    fixed_rem  = neg_a ? ({XLEN{1'b0}} - raw_rem) : raw_rem;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on magnitudes, with a short path for div-by-zero/overflow.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = ITER_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  md_state_e state, next_state;

  logic [2*XLEN-1:0] work;
  logic [XLEN-1:0]   operand, op_a_q, op_b_q, special_val;
  logic [2:0]        func3_q;
  logic [CW-1:0]     cnt;
  logic              special;

  logic              accept, is_div, div_zero, overflow, short_path, last_iter;
  logic [XLEN-1:0]   special_calc, fix_result;
  logic [2:0]        sf_func3;
  logic [XLEN-1:0]   sf_a, sf_b, mag_a, mag_b, fixed_rem;
  logic [2*XLEN-1:0] raw_main, fixed_main;

  logic [XLEN:0]     mul_sum, div_hi;
  logic [2*XLEN-1:0] mul_next, div_next;
  logic [2*XLEN:0]   div_sh;
  logic [XLEN-1:0]   div_diff;

  always_comb begin
    accept    = (state == IDLE) && !done && start && !flush;
    is_div    = func3[2];
    div_zero  = (rs2 == '0);
    overflow  = ((func3 == OP_DIV) || (func3 == OP_REM)) &&
                (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    short_path = is_div && (div_zero || overflow);
    if (div_zero) special_calc = func3[1] ? rs1 : '1;
    else          special_calc = func3[1] ? '0 : rs1;
    last_iter = (cnt == CW'(ITER - 1));
  end

  // Live operands feed the sign unit at accept; latched ones during FIX.
  always_comb begin
    sf_func3 = (state == IDLE) ? func3 : func3_q;
    sf_a     = (state == IDLE) ? rs1 : op_a_q;
    sf_b     = (state == IDLE) ? rs2 : op_b_q;
    raw_main = func3_q[2] ? {{XLEN{1'b0}}, work[XLEN-1:0]} : work;
  end

  muldiv_signfix #(.XLEN(XLEN)) u_signfix (
    .func3      (sf_func3),
    .op_a       (sf_a),
    .op_b       (sf_b),
    .raw_main   (raw_main),
    .raw_rem    (work[2*XLEN-1:XLEN]),
    .mag_a      (mag_a),
    .mag_b      (mag_b),
    .fixed_main (fixed_main),
    .fixed_rem  (fixed_rem)
  );

  always_comb begin
    mul_sum  = {1'b0, work[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, operand} : '0);
    mul_next = {mul_sum, work[XLEN-1:1]};
    div_sh   = {work, 1'b0};
    div_hi   = div_sh[2*XLEN:XLEN];
    div_diff = div_hi[XLEN-1:0] - operand;
    div_next = (div_hi >= {1'b0, operand}) ? {div_diff, div_sh[XLEN-1:1], 1'b1}
                                          : div_sh[2*XLEN-1:0];
  end

  always_comb begin
    fix_result = fixed_main[XLEN-1:0];
    if (special)                   fix_result = special_val;
    else if (!func3_q[2]) begin
      if (func3_q != OP_MUL)       fix_result = fixed_main[2*XLEN-1:XLEN];
    end else if (func3_q[1])       fix_result = fixed_rem;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = short_path ? FIX : CALC;
      CALC:    if (last_iter) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (flush) next_state = IDLE;
  end

  always_comb begin
    busy = (state != IDLE) || done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work        <= '0;
      operand     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      func3_q     <= '0;
      cnt         <= '0;
      special     <= 1'b0;
      special_val <= '0;
      done        <= 1'b0;
      result      <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_a_q      <= rs1;
        op_b_q      <= rs2;
        func3_q     <= func3;
        cnt         <= '0;
        special     <= short_path;
        special_val <= special_calc;
        operand     <= is_div ? mag_b : mag_a;
        work        <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
      end else if (state == CALC && !flush) begin
        work <= func3_q[2] ? div_next : mul_next;
        cnt  <= last_iter ? '0 : cnt + 1'b1;
      end else if (state == FIX && !flush) begin
        result <= fix_result;
        done   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic results, latency,
// short path, flush, mid-op reset and start-while-busy behaviour.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  func3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32), .ITER(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .func3  (func3),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Issues one op; cycles counts rising edges from the accepting edge inclusive.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int cycles, output logic [31:0] res);
    @(negedge clk);
    start = 1'b1; func3 = f; rs1 = a; rs2 = b;
    @(posedge clk);
    cycles = 1;
    @(negedge clk);
    start = 1'b0;
    while (!done && cycles < 100) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    res = result;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; func3 = 3'd0; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++;
    if (result !== 32'h0) begin errors++; $display("[TB] FAIL reset_result: got %h expected 00000000", result); end
    rst = 1'b0;
  endtask

  task automatic test_mul();
    int cyc; logic [31:0] r;
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, cyc, r);
    checks++;
    if (cyc !== 34) begin errors++; $display("[TB] FAIL mul_latency: got %0d expected 34", cyc); end
    checks++;
    if (r !== 32'hFFFFFFEB) begin errors++; $display("[TB] FAIL mul_result: got %h expected ffffffeb", r); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL done_single_pulse: got done=%b busy=%b expected 0 0", done, busy);
    end
    run_op(3'd1, 32'd7, 32'hFFFFFFFD, cyc, r);
    checks++;
    if (r !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mulh_result: got %h expected ffffffff", r); end
    run_op(3'd0, 32'd12345, 32'd6789, cyc, r);
    checks++;
    if (r !== 32'd83810205) begin errors++; $display("[TB] FAIL mul_pos_result: got %h expected %h", r, 32'd83810205); end
  endtask

  task automatic test_mul_variants();
    int cyc; logic [31:0] r;
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, r);
    checks++;
    if (r !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL mulhu_result: got %h expected fffffffe", r); end
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, r);
    checks++;
    if (r !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mulhsu_result: got %h expected ffffffff", r); end
    run_op(3'd2, 32'h00000002, 32'hFFFFFFFF, cyc, r);
    checks++;
    if (r !== 32'h00000001) begin errors++; $display("[TB] FAIL mulhsu_pos_result: got %h expected 00000001", r); end
  endtask

  task automatic test_div();
    int cyc; logic [31:0] r;
    run_op(3'd4, 32'hFFFFFFEC, 32'd6, cyc, r);
    checks++;
    if (cyc !== 34) begin errors++; $display("[TB] FAIL div_latency: got %0d expected 34", cyc); end
    checks++;
    if (r !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL div_result: got %h expected fffffffd", r); end
    run_op(3'd6, 32'hFFFFFFEC, 32'd6, cyc, r);
    checks++;
    if (r !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL rem_result: got %h expected fffffffe", r); end
    run_op(3'd5, 32'd100, 32'd7, cyc, r);
    checks++;
    if (r !== 32'd14) begin errors++; $display("[TB] FAIL divu_result: got %h expected 0000000e", r); end
    run_op(3'd7, 32'hFFFFFFFF, 32'd10, cyc, r);
    checks++;
    if (r !== 32'd5) begin errors++; $display("[TB] FAIL remu_result: got %h expected 00000005", r); end
  endtask

  task automatic test_short_path();
    int cyc; logic [31:0] r;
    run_op(3'd5, 32'd1234, 32'd0, cyc, r);
    checks++;
    if (cyc !== 2) begin errors++; $display("[TB] FAIL divu_zero_latency: got %0d expected 2", cyc); end
    checks++;
    if (r !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL divu_zero_result: got %h expected ffffffff", r); end
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, cyc, r);
    checks++;
    if (cyc !== 2) begin errors++; $display("[TB] FAIL rem_ovf_latency: got %0d expected 2", cyc); end
    checks++;
    if (r !== 32'h0) begin errors++; $display("[TB] FAIL rem_ovf_result: got %h expected 00000000", r); end
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, cyc, r);
    checks++;
    if (r !== 32'h80000000) begin errors++; $display("[TB] FAIL div_ovf_result: got %h expected 80000000", r); end
    run_op(3'd6, 32'h00001234, 32'd0, cyc, r);
    checks++;
    if (r !== 32'h00001234) begin errors++; $display("[TB] FAIL rem_zero_result: got %h expected 00001234", r); end
  endtask

  task automatic test_flush();
    int cyc; int dones; logic [31:0] r;
    run_op(3'd0, 32'd6, 32'd7, cyc, r);
    @(negedge clk);
    start = 1'b1; func3 = 3'd4; rs1 = 32'd100; rs2 = 32'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_mid_op: got %b expected 1", busy); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy: got %b expected 0", busy); end
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("[TB] FAIL flush_no_done: got %0d dones expected 0", dones); end
    checks++;
    if (result !== 32'd42) begin errors++; $display("[TB] FAIL flush_result_kept: got %h expected 0000002a", result); end
    start = 1'b1; flush = 1'b1; func3 = 3'd5; rs1 = 32'd9; rs2 = 32'd0;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL start_flush_same_cycle: got busy=%b done=%b expected 0 0", busy, done);
    end
    run_op(3'd4, 32'd100, 32'd5, cyc, r);
    checks++;
    if (cyc !== 34 || r !== 32'd20) begin
      errors++; $display("[TB] FAIL post_flush_op: got %0d cycles result %h expected 34 cycles 00000014", cyc, r);
    end
  endtask

  task automatic test_rst_mid();
    int dones;
    @(negedge clk);
    start = 1'b1; func3 = 3'd0; rs1 = 32'd11; rs2 = 32'd13;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      errors++; $display("[TB] FAIL rst_mid_outputs: got busy=%b done=%b result=%h expected 0 0 00000000",
                         busy, done, result);
    end
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("[TB] FAIL rst_no_done: got %0d dones expected 0", dones); end
  endtask

  task automatic test_back_to_back();
    int dones;
    dones = 0;
    @(negedge clk);
    start = 1'b1; func3 = 3'd0; rs1 = 32'd3; rs2 = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; func3 = 3'd0; rs1 = 32'd100; rs2 = 32'd100;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    start = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 1) begin errors++; $display("[TB] FAIL busy_start_ignored: got %0d dones expected 1", dones); end
    checks++;
    if (result !== 32'd15) begin errors++; $display("[TB] FAIL busy_start_result: got %h expected 0000000f", result); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mul_variants();
    test_div();
    test_short_path();
    test_flush();
    test_rst_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
